mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter_pkg.sv | 16 +
 rtl/mux2_arbiter_if.sv | 39 +++
 rtl/mux2_arbiter_mux2.sv | 12 +
 rtl/mux2_arbiter.sv | 126 ++++++++++++
 tb/tb_mux2_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter shared types.
// FSM state encodings and small helpers.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Map a requester index to its grant state.
    function automatic state_t grant_of(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Requester-side bundle of the shared mux2 channel.
// master = request sources, slave = arbiter.
interface mux2_arbiter_if;

    logic req0;
    logic req1;
    logic d0;
    logic d1;
    logic gnt0;
    logic gnt1;
    logic s0;
    logic z0;
    logic busy;

    modport master (
        output req0,
        output req1,
        output d0,
        output d1,
        input  gnt0,
        input  gnt1,
        input  s0,
        input  z0,
        input  busy
    );

    modport slave (
        input  req0,
        input  req1,
        input  d0,
        input  d1,
        output gnt0,
        output gnt1,
        output s0,
        output z0,
        output busy
    );

endinterface

// File: rtl/mux2_arbiter_mux2.sv
// Plain 2:1 mux datapath shared by both requesters.
// s0 = 0 selects d0, s0 = 1 selects d1.
module mux2_arbiter_mux2 (
    input  logic s0,
    input  logic d0,
    input  logic d1,
    output logic z0
);

    assign z0 = s0 ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter with bounded hold for one mux2.
// Registered FSM drives the select; output gated when idle.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 4
) (
    input  logic         clk,
    input  logic         rstn,
    mux2_arbiter_if.slave bus
);

    localparam logic [CW-1:0] CNT_TOP = CW'(HOLD_MAX - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          last;
    logic          last_nx;
    logic          s0_q;
    logic          s0_nx;
    logic          g0;
    logic          g1;
    logic          busy;
    logic          mux_z;

    // State, hold counter, round-robin pointer and parked select.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            s0_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
            s0_q  <= s0_nx;
        end
    end

    // Next-state: arbitration, hold timeout and bookkeeping.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        s0_nx    = s0_q;

        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nx = grant_of(~last);
                end else if (bus.req0) begin
                    state_nx = GRANT0;
                end else if (bus.req1) begin
                    state_nx = GRANT1;
                end
            end
            GRANT0: begin
                if (!bus.req0) begin
                    state_nx = bus.req1 ? GRANT1 : IDLE;
                end else if (bus.req1) begin
                    if (cnt == CNT_TOP) begin
                        state_nx = GRANT1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            GRANT1: begin
                if (!bus.req1) begin
                    state_nx = bus.req0 ? GRANT0 : IDLE;
                end else if (bus.req0) begin
                    if (cnt == CNT_TOP) begin
                        state_nx = GRANT0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (state_nx != state) begin
            cnt_nx = '0;
        end

        if (state_nx == GRANT0) begin
            s0_nx = 1'b0;
            if (state != GRANT0) begin
                last_nx = 1'b0;
            end
        end else if (state_nx == GRANT1) begin
            s0_nx = 1'b1;
            if (state != GRANT1) begin
                last_nx = 1'b1;
            end
        end
    end

    assign g0   = (state == GRANT0);
    assign g1   = (state == GRANT1);
    assign busy = g0 | g1;

    mux2_arbiter_mux2 u_mux2 (
        .s0 (s0_q),
        .d0 (bus.d0),
        .d1 (bus.d1),
        .z0 (mux_z)
    );

    assign bus.gnt0 = g0;
    assign bus.gnt1 = g1;
    assign bus.busy = busy;
    assign bus.s0   = s0_q;
    assign bus.z0   = mux_z & busy;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter.
// HOLD_MAX=8, CW=4; checks at posedge+1.
module tb_mux2_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    mux2_arbiter_if bus ();

    mux2_arbiter #(
        .HOLD_MAX (8),
        .CW       (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("%s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 1'b0;
        bus.d1   = 1'b0;
        #3;

        // reset state, forced with both requests high
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_gnt1", bus.gnt1, 1'b0);
        chk("rst_s0",   bus.s0,   1'b0);
        chk("rst_z0",   bus.z0,   1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        tick();
        tick();
        chk("rst_hold_gnt0", bus.gnt0, 1'b0);

        // release: last=1 so requester 0 wins
        rstn = 1'b1;
        tick();
        chk("rel_gnt0", bus.gnt0, 1'b1);
        chk("rel_gnt1", bus.gnt1, 1'b0);
        chk("rel_s0",   bus.s0,   1'b0);

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 1'b0);

        // single requester 1
        bus.req1 = 1'b1;
        bus.d1   = 1'b1;
        bus.d0   = 1'b0;
        tick();
        chk("single_gnt1", bus.gnt1, 1'b1);
        chk("single_s0",   bus.s0,   1'b1);
        chk("single_z0",   bus.z0,   1'b1);
        bus.req1 = 1'b0;
        tick();
        chk("drop_gnt1", bus.gnt1, 1'b0);
        chk("drop_z0",   bus.z0,   1'b0);
        chk("park_s0",   bus.s0,   1'b1);

        // make last=0 via a grant to requester 0
        bus.req0 = 1'b1;
        tick();
        chk("pre_gnt0", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        tick();
        chk("pre_idle", bus.busy, 1'b0);

        // contention with last=0 goes to 1, then direct hand-off
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        chk("rr_gnt1", bus.gnt1, 1'b1);
        chk("rr_gnt0_lo", bus.gnt0, 1'b0);
        bus.req1 = 1'b0;
        tick();
        chk("handoff_gnt0", bus.gnt0, 1'b1);
        chk("handoff_busy", bus.busy, 1'b1);

        // hold timeout: gnt0 for 8 cycles after req1 rises
        bus.req1 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("hold0_%0d", i), bus.gnt0, 1'b1);
        end
        tick();
        chk("timeout_gnt1", bus.gnt1, 1'b1);
        chk("timeout_s0",   bus.s0,   1'b1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("hold1_%0d", i), bus.gnt1, 1'b1);
        end
        tick();
        chk("return_gnt0", bus.gnt0, 1'b1);
        chk("excl", bus.gnt0 & bus.gnt1, 1'b0);

        // data sweep in GRANT0: z0 follows d0
        bus.req1 = 1'b0;
        tick();
        chk("g0_steady", bus.gnt0, 1'b1);
        {bus.d1, bus.d0} = 2'b00; #1; chk("g0_d00", bus.z0, 1'b0);
        {bus.d1, bus.d0} = 2'b01; #1; chk("g0_d01", bus.z0, 1'b1);
        {bus.d1, bus.d0} = 2'b10; #1; chk("g0_d10", bus.z0, 1'b0);
        {bus.d1, bus.d0} = 2'b11; #1; chk("g0_d11", bus.z0, 1'b1);

        // data sweep in GRANT1: z0 follows d1
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        tick();
        chk("g1_direct", bus.gnt1, 1'b1);
        {bus.d1, bus.d0} = 2'b00; #1; chk("g1_d00", bus.z0, 1'b0);
        {bus.d1, bus.d0} = 2'b01; #1; chk("g1_d01", bus.z0, 1'b0);
        {bus.d1, bus.d0} = 2'b10; #1; chk("g1_d10", bus.z0, 1'b1);
        {bus.d1, bus.d0} = 2'b11; #1; chk("g1_d11", bus.z0, 1'b1);

        // async reset mid-grant, between edges
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_gnt1", bus.gnt1, 1'b0);
        chk("arst_z0",   bus.z0,   1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_s0",   bus.s0,   1'b0);
        #1;
        rstn = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        chk("post_rst_gnt0", bus.gnt0, 1'b1);
        chk("post_rst_gnt1", bus.gnt1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
